// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the i2c_master_top command sequencer: core register map,
// CR/SR bit layout, FSM state and response-code enums.
package i2c_seq_pkg;

    localparam logic [2:0] REG_PRERLO = 3'd0;
    localparam logic [2:0] REG_PRERHI = 3'd1;
    localparam logic [2:0] REG_CTR    = 3'd2;
    localparam logic [2:0] REG_TXR    = 3'd3;
    localparam logic [2:0] REG_RXR    = 3'd3;
    localparam logic [2:0] REG_CR     = 3'd4;
    localparam logic [2:0] REG_SR     = 3'd4;

    localparam logic [7:0] CTR_EN = 8'h80;
    localparam logic [7:0] CR_STA = 8'h80;
    localparam logic [7:0] CR_STO = 8'h40;
    localparam logic [7:0] CR_RD  = 8'h20;
    localparam logic [7:0] CR_WR  = 8'h10;
    localparam logic [7:0] CR_ACK = 8'h08;

    localparam int SR_TIP   = 1;
    localparam int SR_AL    = 5;
    localparam int SR_RXACK = 7;

    typedef enum logic [3:0] {
        S_INIT_PRLO, S_INIT_PRHI, S_INIT_CTR, S_IDLE, S_LOAD_TXR, S_WRITE_CR,
        S_POLL_SR, S_CHECK, S_READ_RXR, S_ABORT_STO, S_ABORT_POLL, S_RESP
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_NACK    = 2'b01,
        ERR_ARBLOST = 2'b10,
        ERR_TIMEOUT = 2'b11
    } seq_err_e;

    // Step 2 is the data byte for writes but the repeated START for reads.
    function automatic logic [7:0] cr_for(input logic [1:0] step, input logic rw);
        case (step)
            2'd0:    cr_for = CR_STA | CR_WR;
            2'd1:    cr_for = CR_WR;
            2'd2:    cr_for = rw ? (CR_STA | CR_WR) : (CR_WR | CR_STO);
            default: cr_for = CR_RD | CR_ACK | CR_STO;
        endcase
    endfunction

endpackage

// File: rtl/i2c_seq_wb_access.sv
// Single-access Wishbone master: a start pulse launches one registered cycle that is
// held until ack; done pulses with the captured read data on the cycle after ack.
module i2c_seq_wb_access (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] addr,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic [2:0] wb_addr,
    output logic [7:0] wb_wdata,
    input  logic [7:0] wb_rdata,
    output logic       wb_we,
    output logic       wb_stb,
    output logic       wb_cyc,
    input  logic       wb_ack
);

    always_ff @(posedge clock) begin
        if (reset) begin
            done     <= 1'b0;
            rdata    <= 8'h00;
            wb_addr  <= 3'd0;
            wb_wdata <= 8'h00;
            wb_we    <= 1'b0;
            wb_stb   <= 1'b0;
            wb_cyc   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wb_cyc) begin
                if (wb_ack) begin
                    wb_cyc <= 1'b0;
                    wb_stb <= 1'b0;
                    wb_we  <= 1'b0;
                    done   <= 1'b1;
                    rdata  <= wb_rdata;
                end
            end else if (start) begin
                wb_cyc   <= 1'b1;
                wb_stb   <= 1'b1;
                wb_we    <= we;
                wb_addr  <= addr;
                wb_wdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/i2c_wb_cmd_seq.sv
// Command sequencer for i2c_master_top: expands register read/write commands into
// core register accesses. Define I2C_SEQ_TIMEOUT_EN to bound SR polling (err 11).
module i2c_wb_cmd_seq
    import i2c_seq_pkg::*;
#(
    parameter logic [15:0] PRESCALE = 16'd49
`ifdef I2C_SEQ_TIMEOUT_EN
    ,
    parameter logic [15:0] POLL_LIMIT = 16'd4095
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic [2:0] wb_addr,
    output logic [7:0] wb_wdata,
    input  logic [7:0] wb_rdata,
    output logic       wb_we,
    output logic       wb_stb,
    output logic       wb_cyc,
    input  logic       wb_ack,
    output seq_state_e state
);

    logic       start, issued, acc_done, acc_state, acc_we, poll_expired;
    logic [2:0] acc_addr;
    logic [7:0] acc_wdata, acc_rdata, txr_val;
    logic [1:0] step;
    logic       rw, sr_al, sr_rxack;
    logic [6:0] dev;
    logic [7:0] reg_idx, wdata;
    seq_err_e   err;

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [15:0] poll_cnt;
    assign poll_expired = (poll_cnt == POLL_LIMIT - 16'd1);
`else
    assign poll_expired = 1'b0;
`endif

    i2c_seq_wb_access u_access (
        .clock(clock), .reset(reset), .start(start), .addr(acc_addr), .we(acc_we),
        .wdata(acc_wdata), .done(acc_done), .rdata(acc_rdata),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata), .wb_we(wb_we),
        .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
    );

    always_comb begin
        case (step)
            2'd0:    txr_val = {dev, 1'b0};
            2'd1:    txr_val = reg_idx;
            2'd2:    txr_val = rw ? {dev, 1'b1} : wdata;
            default: txr_val = 8'h00;
        endcase
    end

    // Each access state owns exactly one Wishbone access, described here.
    always_comb begin
        acc_state = 1'b1;
        acc_addr  = REG_PRERLO;
        acc_we    = 1'b0;
        acc_wdata = 8'h00;
        case (state)
            S_INIT_PRLO:  begin acc_we = 1'b1; acc_wdata = PRESCALE[7:0]; end
            S_INIT_PRHI:  begin acc_addr = REG_PRERHI; acc_we = 1'b1; acc_wdata = PRESCALE[15:8]; end
            S_INIT_CTR:   begin acc_addr = REG_CTR; acc_we = 1'b1; acc_wdata = CTR_EN; end
            S_LOAD_TXR:   begin acc_addr = REG_TXR; acc_we = 1'b1; acc_wdata = txr_val; end
            S_WRITE_CR:   begin acc_addr = REG_CR; acc_we = 1'b1; acc_wdata = cr_for(step, rw); end
            S_ABORT_STO:  begin acc_addr = REG_CR; acc_we = 1'b1; acc_wdata = CR_STO; end
            S_POLL_SR,
            S_ABORT_POLL: acc_addr = REG_SR;
            S_READ_RXR:   acc_addr = REG_RXR;
            default:      acc_state = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_INIT_PRLO;
            start     <= 1'b0;
            issued    <= 1'b0;
            step      <= 2'd0;
            rw        <= 1'b0;
            dev       <= 7'd0;
            reg_idx   <= 8'h00;
            wdata     <= 8'h00;
            err       <= ERR_OK;
            sr_al     <= 1'b0;
            sr_rxack  <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 2'b00;
`ifdef I2C_SEQ_TIMEOUT_EN
            poll_cnt  <= 16'd0;
`endif
        end else begin
            start     <= 1'b0;
            rsp_valid <= 1'b0;
            if (acc_state && !issued) begin
                start  <= 1'b1;
                issued <= 1'b1;
            end
            if (acc_done) issued <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            if (acc_done && (state == S_POLL_SR || state == S_ABORT_POLL)) poll_cnt <= poll_cnt + 16'd1;
            if (acc_done && (state == S_WRITE_CR || state == S_ABORT_STO)) poll_cnt <= 16'd0;
`endif
            case (state)
                S_INIT_PRLO: if (acc_done) state <= S_INIT_PRHI;
                S_INIT_PRHI: if (acc_done) state <= S_INIT_CTR;
                S_INIT_CTR: if (acc_done) begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
                S_IDLE: if (cmd_valid && cmd_ready) begin
                    rw        <= cmd_rw;
                    dev       <= cmd_dev;
                    reg_idx   <= cmd_reg;
                    wdata     <= cmd_wdata;
                    step      <= 2'd0;
                    err       <= ERR_OK;
                    cmd_ready <= 1'b0;
                    state     <= S_LOAD_TXR;
                end
                S_LOAD_TXR: if (acc_done) state <= S_WRITE_CR;
                S_WRITE_CR: if (acc_done) state <= S_POLL_SR;
                S_POLL_SR: if (acc_done) begin
                    if (!acc_rdata[SR_TIP]) begin
                        sr_al    <= acc_rdata[SR_AL];
                        sr_rxack <= acc_rdata[SR_RXACK];
                        state    <= S_CHECK;
                    end else if (poll_expired) begin
                        err   <= ERR_TIMEOUT;
                        state <= S_ABORT_STO;
                    end
                end
                S_CHECK: begin
                    // Arbitration loss leaves the bus to the winner, so no STOP.
                    if (sr_al) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= ERR_ARBLOST;
                        rsp_rdata <= 8'h00;
                        state     <= S_RESP;
                    end else if (sr_rxack && step != 2'd3) begin
                        err   <= ERR_NACK;
                        state <= S_ABORT_STO;
                    end else if (step == (rw ? 2'd3 : 2'd2)) begin
                        if (rw) begin
                            state <= S_READ_RXR;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= ERR_OK;
                            rsp_rdata <= 8'h00;
                            state     <= S_RESP;
                        end
                    end else begin
                        step  <= step + 2'd1;
                        state <= (rw && step == 2'd2) ? S_WRITE_CR : S_LOAD_TXR;
                    end
                end
                S_READ_RXR: if (acc_done) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= ERR_OK;
                    rsp_rdata <= acc_rdata;
                    state     <= S_RESP;
                end
                S_ABORT_STO: if (acc_done) state <= S_ABORT_POLL;
                S_ABORT_POLL: if (acc_done && (!acc_rdata[SR_TIP] || poll_expired)) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err;
                    rsp_rdata <= 8'h00;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_INIT_PRLO;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_wb_cmd_seq.sv
// Bench for i2c_wb_cmd_seq with a behavioural i2c_master_top register model.
// The timeout case is compiled in only when I2C_SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_i2c_wb_cmd_seq;
    import i2c_seq_pkg::*;

    localparam int TIMEOUT = 3000;
`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int LONG_BUSY = 15;
`else
    localparam int LONG_BUSY = 40;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0, cmd_rw = 1'b0;
    logic [6:0] cmd_dev = 7'd0;
    logic [7:0] cmd_reg = 8'h00, cmd_wdata = 8'h00;
    logic       cmd_ready, rsp_valid, wb_we, wb_stb, wb_cyc;
    logic [7:0] rsp_rdata, wb_wdata;
    logic [1:0] rsp_err;
    logic [2:0] wb_addr;
    logic [7:0] wb_rdata = 8'h00;
    logic       wb_ack = 1'b0;
    seq_state_e state;

    always #5 clock = ~clock;

    i2c_wb_cmd_seq #(
        .PRESCALE(16'h0031)
`ifdef I2C_SEQ_TIMEOUT_EN
        , .POLL_LIMIT(16'd16)
`endif
    ) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata), .wb_we(wb_we),
        .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_ack(wb_ack), .state(state)
    );

    // Core model knobs: busy SR reads per CR write, per-CR-index RxACK/AL flags.
    int         busy_polls = 0;
    logic [7:0] nack_mask = 8'h00, al_mask = 8'h00, rxr_val = 8'h00;
    logic       hold_scl = 1'b0, clr_log = 1'b1;

    logic [10:0] wr_log[$];
    int cr_idx = 0, sr_reads = 0, sr_at_abort = -1, tip_left = 0;

    always @(posedge clock) begin
        wb_ack <= 1'b0;
        if (clr_log) begin
            wr_log.delete();
            cr_idx      <= 0;
            sr_reads    <= 0;
            sr_at_abort <= -1;
            tip_left    <= 0;
        end else if (wb_cyc && wb_stb && !wb_ack) begin
            wb_ack <= 1'b1;
            if (wb_we) begin
                wr_log.push_back({wb_addr, wb_wdata});
                if (wb_addr == REG_CR) begin
                    cr_idx   <= cr_idx + 1;
                    tip_left <= busy_polls;
                    if (wb_wdata == CR_STO && sr_at_abort < 0) sr_at_abort <= sr_reads;
                end
            end else if (wb_addr == REG_SR) begin
                sr_reads <= sr_reads + 1;
                if (hold_scl || tip_left > 0) begin
                    wb_rdata <= 8'h02;
                    if (tip_left > 0) tip_left <= tip_left - 1;
                end else begin
                    wb_rdata <= {nack_mask[cr_idx-1], 1'b0, al_mask[cr_idx-1], 5'b00000};
                end
            end else begin
                wb_rdata <= rxr_val;
            end
        end
    end

    // Wishbone protocol monitor: held request until ack, drop on the cycle after ack.
    int         proto_err = 0;
    logic       p_cyc = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [2:0] p_addr = 3'd0;
    logic [7:0] p_wd = 8'h00;
    always @(negedge clock) begin
        if (!reset) begin
            if (p_cyc && p_ack && wb_cyc) proto_err++;
            if (p_cyc && !p_ack && !(wb_cyc && wb_stb && wb_addr == p_addr &&
                                     wb_we == p_we && wb_wdata == p_wd)) proto_err++;
            if (wb_cyc != wb_stb) proto_err++;
        end
        p_cyc  = wb_cyc && !reset;
        p_ack  = wb_ack;
        p_addr = wb_addr;
        p_we   = wb_we;
        p_wd   = wb_wdata;
    end

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rw;
        logic [6:0]  dev;
        logic [7:0]  rg, wd, nack, al, rxr;
        int          busy;
        logic [1:0]  exp_err;
        logic [7:0]  exp_rdata;
        int          exp_sr, exp_n;
        logic [87:0] lg;
    } vec_t;
    vec_t vq[$];

    task automatic add_vec(input logic rw, input logic [6:0] dev, input logic [7:0] rg, wd,
                           input logic [7:0] nack, al, rxr, input int busy,
                           input logic [1:0] e, input logic [7:0] rd, input int sr, n,
                           input logic [87:0] lg);
        vec_t v;
        v.rw = rw; v.dev = dev; v.rg = rg; v.wd = wd; v.nack = nack; v.al = al; v.rxr = rxr;
        v.busy = busy; v.exp_err = e; v.exp_rdata = rd; v.exp_sr = sr; v.exp_n = n; v.lg = lg;
        vq.push_back(v);
    endtask

    task automatic send_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg, wd,
                            input string tag);
        int n = 0;
        clr_log = 1'b1;
        @(negedge clock);
        clr_log = 1'b0;
        cmd_rw = rw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd; cmd_valid = 1'b1;
        while (!cmd_ready && n < TIMEOUT) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_accept"}, 32'(n < TIMEOUT), 32'd1);
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_rw    = 1'($urandom_range(0, 1));
        cmd_dev   = 7'($urandom_range(0, 127));
        cmd_reg   = 8'($urandom_range(0, 255));
        cmd_wdata = 8'($urandom_range(0, 255));
        chk({tag, "_ready_drop"}, 32'(cmd_ready), 32'd0);
    endtask

    task automatic wait_rsp(output logic [1:0] e, output logic [7:0] rd, input string tag);
        int n = 0;
        while (!rsp_valid && n < TIMEOUT) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_rsp_seen"}, 32'(n < TIMEOUT), 32'd1);
        chk({tag, "_ready_in_resp"}, 32'(cmd_ready), 32'd0);
        e  = rsp_err;
        rd = rsp_rdata;
        @(negedge clock);
        chk({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic check_log(input string tag, input int exp_n, input logic [87:0] lg);
        chk({tag, "_log_len"}, 32'(wr_log.size()), 32'(exp_n));
        for (int k = 0; k < exp_n; k++)
            if (k < wr_log.size())
                chk($sformatf("%s_log%0d", tag, k), 32'(wr_log[k]), 32'(lg[87-11*k -: 11]));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [1:0] e;
        logic [7:0] rd;
        busy_polls = v.busy; nack_mask = v.nack; al_mask = v.al; rxr_val = v.rxr;
        send_cmd(v.rw, v.dev, v.rg, v.wd, tag);
        wait_rsp(e, rd, tag);
        chk({tag, "_err"}, 32'(e), 32'(v.exp_err));
        chk({tag, "_rdata"}, 32'(rd), 32'(v.exp_rdata));
        chk({tag, "_sr_reads"}, 32'(sr_reads), 32'(v.exp_sr));
        check_log(tag, v.exp_n, v.lg);
    endtask

    task automatic check_init(input string tag);
        int n = 0;
        while (!cmd_ready && n < TIMEOUT) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_ready"}, 32'(n < TIMEOUT), 32'd1);
        chk({tag, "_state_idle"}, 32'(state), 32'(S_IDLE));
        check_log(tag, 3, {11'h031, 11'h100, 11'h280, 55'd0});
    endtask

    initial begin
        int n;
        logic [1:0] e;
        logic [7:0] rd;

        add_vec(0, 7'h50, 8'h10, 8'hA5, 8'h00, 8'h00, 8'h00, 2, 2'b00, 8'h00, 9, 6,
                {11'h3A0, 11'h490, 11'h310, 11'h410, 11'h3A5, 11'h450, 22'd0});
        add_vec(1, 7'h50, 8'h10, 8'h00, 8'h08, 8'h00, 8'h3C, 0, 2'b00, 8'h3C, 4, 7,
                {11'h3A0, 11'h490, 11'h310, 11'h410, 11'h3A1, 11'h490, 11'h468, 11'd0});
        add_vec(0, 7'h22, 8'h10, 8'hA5, 8'h01, 8'h00, 8'h00, 1, 2'b01, 8'h00, 4, 3,
                {11'h344, 11'h490, 11'h440, 55'd0});
        add_vec(0, 7'h2A, 8'h33, 8'h5C, 8'h00, 8'h02, 8'h00, 3, 2'b10, 8'h00, 8, 4,
                {11'h354, 11'h490, 11'h333, 11'h410, 44'd0});
        add_vec(0, 7'h7F, 8'hFF, 8'h00, 8'h04, 8'h00, 8'h00, 0, 2'b01, 8'h00, 4, 7,
                {11'h3FE, 11'h490, 11'h3FF, 11'h410, 11'h300, 11'h450, 11'h440, 11'd0});
        add_vec(1, 7'h01, 8'h00, 8'h00, 8'h04, 8'h00, 8'h77, 1, 2'b01, 8'h00, 8, 7,
                {11'h302, 11'h490, 11'h300, 11'h410, 11'h303, 11'h490, 11'h440, 11'd0});
        add_vec(0, 7'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, LONG_BUSY, 2'b00, 8'h00,
                3 * (LONG_BUSY + 1), 6,
                {11'h322, 11'h490, 11'h322, 11'h410, 11'h333, 11'h450, 22'd0});
        add_vec(1, 7'h40, 8'h01, 8'h00, 8'h00, 8'h04, 8'hAA, 0, 2'b10, 8'h00, 3, 6,
                {11'h380, 11'h490, 11'h301, 11'h410, 11'h381, 11'h490, 22'd0});

        repeat (3) @(negedge clock);
        chk("reset_state", 32'(state), 32'(S_INIT_PRLO));
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset_cyc", 32'(wb_cyc), 32'd0);
        chk("reset_stb", 32'(wb_stb), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp", 32'({rsp_err, rsp_rdata}), 32'd0);
        reset   = 1'b0;
        clr_log = 1'b0;
        check_init("init");

        for (int i = 0; i < vq.size(); i++) run_vec(vq[i], $sformatf("v%0d", i));

        // Reset while polling SR after the register byte's CR write.
        busy_polls = 10; nack_mask = 8'h00; al_mask = 8'h00;
        send_cmd(0, 7'h50, 8'h10, 8'hA5, "rst");
        n = 0;
        while (!(state == S_POLL_SR && cr_idx == 2 && wb_cyc) && n < TIMEOUT) begin
            @(negedge clock);
            n++;
        end
        chk("rst_reach_poll", 32'(n < TIMEOUT), 32'd1);
        reset   = 1'b1;
        clr_log = 1'b1;
        @(negedge clock);
        chk("rst_cyc_drop", 32'(wb_cyc), 32'd0);
        chk("rst_state", 32'(state), 32'(S_INIT_PRLO));
        chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        reset   = 1'b0;
        clr_log = 1'b0;
        check_init("rst_init");
        run_vec(vq[0], "rst_cmd");

`ifdef I2C_SEQ_TIMEOUT_EN
        busy_polls = 0; nack_mask = 8'h00; al_mask = 8'h00; hold_scl = 1'b1;
        send_cmd(0, 7'h50, 8'h10, 8'hA5, "tmo");
        wait_rsp(e, rd, "tmo");
        chk("tmo_err", 32'(e), 32'(ERR_TIMEOUT));
        chk("tmo_rdata", 32'(rd), 32'd0);
        chk("tmo_polls_before_sto", 32'(sr_at_abort), 32'd16);
        chk("tmo_total_polls", 32'(sr_reads), 32'd32);
        check_log("tmo", 3, {11'h3A0, 11'h490, 11'h440, 55'd0});
        hold_scl = 1'b0;
`else
        e  = 2'b00;
        rd = 8'h00;
`endif

        chk("wb_protocol", 32'(proto_err), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
